// File: rtl/bin2bcd_8bits.sv
// -----------------------------------------------------------------------------
// bin2bcd_8bits
//
// Sequential binary-to-BCD converter for the 8-bit product of the 4-bit
// multiplier. It uses the shift-and-add-3 (double dabble) method: one
// iteration per clock, eight iterations per conversion. The result is three
// packed BCD digits for the display stage.
//
// Ports:
//   clk_i        in   1  clock, rising edge
//   rst_i        in   1  asynchronous reset, active-low
//   data_i       in   8  unsigned binary value, sampled only on acceptance
//   start_i      in   1  level request, accepted in IDLE when high
//   bcd_o        out 12  [11:8]=hundreds, [7:4]=tens, [3:0]=units (registered)
//   busy_o       out  1  high while in SHIFT
//   done_o       out  1  high while in DONE
//   fsm_state_o  out  2  current state encoding (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: a request is accepted on a rising edge where the FSM is in IDLE
// and start_i is high. The FSM then leaves DONE only after start_i has been
// seen low, so a level request held high yields exactly one conversion.
// -----------------------------------------------------------------------------
module bin2bcd_8bits (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  data_i,
  input  logic        start_i,
  output logic [11:0] bcd_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  fsm_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [11:0] bcd_q,   bcd_d;
  logic [19:0] step;

  // One double-dabble iteration: correct every BCD nibble that would exceed
  // 9 after doubling, then shift the whole register left by one.
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  assign step = dabble_step(shreg_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        // bcd_q is deliberately left alone so the display keeps the last
        // result while a new conversion runs.
        if (start_i) begin
          shreg_d = {12'b0, data_i};
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = step;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          bcd_d   = step[19:8];
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start_i) state_d = IDLE;
      end
      default: begin
        // Unused code 2'd3: recover to IDLE without touching the outputs.
        state_d = IDLE;
      end
    endcase
  end

  assign bcd_o       = bcd_q;
  assign busy_o      = (state_q == SHIFT);
  assign done_o      = (state_q == DONE);
  assign fsm_state_o = state_q;

endmodule

// File: doc/bin2bcd_8bits.md
Name: bin2bcd_8bits

Overview:
Sequential binary-to-BCD converter for the 8-bit product leaving the 4-bit multiplier stage. It uses the shift-and-add-3 (double dabble) method and produces three packed BCD digits (hundreds, tens, units) for the display stage. It connects directly to the multiplier: `data_i` takes the product and `start_i` takes the multiplier's level `done` flag. One conversion per `start_i` assertion; a `start_i` held high does not retrigger.

Parameters:
None. Widths are fixed: 8-bit binary in, 3 BCD digits (12 bits) out.

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  asynchronous reset, active-low
data_i  input  8  unsigned binary value (0..255); sampled only on acceptance
start_i  input  1  level request; accepted in IDLE when high
bcd_o  output  12  result, [11:8]=hundreds, [7:4]=tens, [3:0]=units; registered
busy_o  output  1  high while in SHIFT
done_o  output  1  high while in DONE; registered state decode
fsm_state_o  output  2  current state encoding, for debug/observation

Behaviour:
- Reset (`rst_i`=0, async, any time including mid-conversion):
  - state=IDLE, `bcd_o`=12'h000, `busy_o`=0, `done_o`=0, `fsm_state_o`=2'd0.
  - Internal 20-bit shift register and 4-bit iteration counter are cleared.
  - Release resumes normal operation from IDLE.
- State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2. Code 2'd3 is illegal and returns to IDLE on the next edge with no output change.
- IDLE:
  - On an edge with `start_i`=1: shift register <= {12'b0, `data_i`}, counter <= 0, state -> SHIFT.
  - Otherwise stay in IDLE.
  - `bcd_o` keeps its previous value and is not cleared on acceptance.
- SHIFT: one iteration per clock, exactly 8 iterations.
  - Each iteration, combinationally on the current shift register:
    - For each of the three BCD nibbles (bits [19:16], [15:12], [11:8]), add 3 if the nibble is >= 5.
    - Then shift the whole 20-bit value left by 1, filling with 0.
    - Register the result.
  - Counter increments each iteration.
  - On the edge performing iteration 8 (counter==7): `bcd_o` <= upper 12 bits of the new value, state -> DONE.
  - `data_i` and `start_i` are ignored while in SHIFT.
- DONE:
  - `done_o`=1.
  - Stay while `start_i`=1, so a level done from the multiplier yields exactly one conversion.
  - When `start_i`=0 on an edge, state -> IDLE.
- Latency: acceptance at edge k; `done_o`=1 and `bcd_o` valid after edge k+8. Minimum request-to-request period is 10 cycles (8 SHIFT + DONE + IDLE).
- Range: input max 255 gives hundreds digit <= 2. Every output digit is a legal BCD value 0..9.
- `busy_o` and `done_o` are never high together. `busy_o` = (state==SHIFT). `done_o` = (state==DONE).

Test Plan:
- Reset then idle: `rst_i` low 2 cycles, `start_i`=0 for 5 cycles -> `bcd_o`=12'h000, `done_o`=0, `busy_o`=0, `fsm_state_o`=0 throughout.
- Multiplier max product: `data_i`=8'd225 (15*15), `start_i` pulsed high 1 cycle -> `busy_o` high exactly 8 cycles, then `done_o`=1 with `bcd_o`=12'h225. `start_i` already low, so state returns to IDLE one cycle later.
- Boundary values, one conversion each with `start_i` low between requests:
  - 0 -> 12'h000
  - 9 -> 12'h009
  - 10 -> 12'h010
  - 99 -> 12'h099
  - 100 -> 12'h100
  - 255 -> 12'h255
  - Exhaustive sweep 0..255 checked against a reference model.
- Level start, no retrigger: `start_i` held high 30 cycles with `data_i`=8'd42 -> exactly one SHIFT burst, `done_o` stays 1 with `bcd_o`=12'h042. Dropping `start_i` -> IDLE next edge.
- Input change during conversion: accept `data_i`=8'd137, then switch `data_i` to 8'd64 during SHIFT -> result is 12'h137.
- Reset mid-operation: assert `rst_i` low asynchronously on the 4th SHIFT cycle of a conversion of 200 -> outputs clear immediately, `bcd_o`=12'h000. After release, a new request with 8'd58 -> 12'h058 after 8 cycles.
